// File: rtl/a2s_pkg.sv
// rtl/a2s_pkg.sv - shared types and helpers for the async-to-sync receive path
package a2s_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACKED = 1'b1
    } a2s_rx_state_t;

    // Pointer width carries one extra wrap bit so full and empty are distinguishable.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/a2s_rx_fifo_if.sv
// rtl/a2s_rx_fifo_if.sv - handshake, stream and status bundle of the a2s receive FIFO
interface a2s_rx_fifo_if
    import a2s_pkg::*;
#(
    parameter int DW    = 64,
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) ();

    logic                      Si;
    logic [DW-1:0]             Din;
    logic                      So;
    logic [DW-1:0]             Dout;
    logic                      Dvalid;
    logic                      Dready;
    logic [ptr_w(DEPTH)-1:0]   Level;
    logic [CNT_W-1:0]          RxCount;
    logic                      ProtoErr;

    modport slave (
        input  Si, Din, Dready,
        output So, Dout, Dvalid, Level, RxCount, ProtoErr
    );

    modport master (
        output Si, Din, Dready,
        input  So, Dout, Dvalid, Level, RxCount, ProtoErr
    );

endinterface

// File: rtl/cdc_sync_chain.sv
// rtl/cdc_sync_chain.sv - reset-to-0 flop chain for a single asynchronous level
module cdc_sync_chain #(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic RESET,
    input  logic d,
    output logic q
);

    generate
        if (STAGES == 0) begin : g_wire
            // Source is already synchronous to CLK.
            assign q = d;
        end else begin : g_chain
            logic [STAGES-1:0] r_chain;

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    r_chain <= '0;
                end else begin
                    r_chain[0] <= d;
                    for (int i = 1; i < STAGES; i++) begin
                        r_chain[i] <= r_chain[i-1];
                    end
                end
            end

            assign q = r_chain[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/a2s_rx_fifo.sv
// rtl/a2s_rx_fifo.sv - CLK-side 4-phase receive endpoint buffering words into a valid/ready FIFO
module a2s_rx_fifo
    import a2s_pkg::*;
#(
    parameter int DW          = 64,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 32
) (
    input  logic          CLK,
    input  logic          RESET,
    a2s_rx_fifo_if.slave  rx
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic                      w_si_s;
    logic                      r_si_d;
    a2s_rx_state_t             r_state;
    a2s_rx_state_t             w_state_nxt;

    logic [DEPTH-1:0][DW-1:0]  r_mem;
    logic [PW-1:0]             r_wr_ptr;
    logic [PW-1:0]             r_rd_ptr;
    logic [CNT_W-1:0]          r_rx_count;
    logic                      r_proto_err;

    logic                      w_empty;
    logic                      w_full;
    logic                      w_pop;
    logic                      w_accept;
    logic                      w_push;
    logic                      w_err_set;

    cdc_sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_si_sync (
        .CLK   (CLK),
        .RESET (RESET),
        .d     (rx.Si),
        .q     (w_si_s)
    );

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop    = !w_empty && rx.Dready;
    // A full FIFO can still take a word on the edge where its head is consumed.
    assign w_accept = !w_full || w_pop;

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_si_s) begin
                    if (w_accept) begin
                        w_push      = 1'b1;
                        w_state_nxt = ACKED;
                    end
                end else if (r_si_d) begin
                    // Request fell while we were still stalling it.
                    w_err_set = 1'b1;
                end
            end
            ACKED: begin
                if (!w_si_s) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_si_d      <= 1'b0;
            r_state     <= IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_rx_count  <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_si_d  <= w_si_s;
            r_state <= w_state_nxt;
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + PW'(1);
                r_rx_count <= r_rx_count + CNT_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_err_set) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= rx.Din;
        end
    end

    assign rx.So       = (r_state == ACKED);
    assign rx.Dout     = r_mem[r_rd_ptr[AW-1:0]];
    assign rx.Dvalid   = !w_empty;
    assign rx.Level    = r_wr_ptr - r_rd_ptr;
    assign rx.RxCount  = r_rx_count;
    assign rx.ProtoErr = r_proto_err;

endmodule

// File: tb/tb_a2s_rx_fifo.sv
// tb/tb_a2s_rx_fifo.sv - self-checking bench for a2s_rx_fifo with counter-width and sync-depth variants
module tb_a2s_rx_fifo;

    logic CLK = 1'b0;
    logic RESET;

    always #5 CLK = ~CLK;

    a2s_rx_fifo_if #(.DW(64), .DEPTH(4), .CNT_W(32)) m_if ();
    a2s_rx_fifo_if #(.DW(64), .DEPTH(4), .CNT_W(4))  c4_if ();
    a2s_rx_fifo_if #(.DW(64), .DEPTH(4), .CNT_W(32)) s0_if ();

    assign c4_if.Si     = m_if.Si;
    assign c4_if.Din    = m_if.Din;
    assign c4_if.Dready = 1'b1;
    assign s0_if.Si     = m_if.Si;
    assign s0_if.Din    = m_if.Din;
    assign s0_if.Dready = 1'b1;

    a2s_rx_fifo #(.DW(64), .DEPTH(4), .SYNC_STAGES(2), .CNT_W(32)) u_dut (
        .CLK   (CLK),
        .RESET (RESET),
        .rx    (m_if.slave)
    );

    a2s_rx_fifo #(.DW(64), .DEPTH(4), .SYNC_STAGES(2), .CNT_W(4)) u_dut_c4 (
        .CLK   (CLK),
        .RESET (RESET),
        .rx    (c4_if.slave)
    );

    a2s_rx_fifo #(.DW(64), .DEPTH(4), .SYNC_STAGES(0), .CNT_W(32)) u_dut_s0 (
        .CLK   (CLK),
        .RESET (RESET),
        .rx    (s0_if.slave)
    );

    typedef struct {
        logic [63:0] din;
        bit          exp_ack;
        int          exp_level;
    } bp_vec_t;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          rand_ready = 1'b0;
    logic [63:0] sbq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: score any pop at the negedge, then return 1 time unit after the posedge.
    task automatic tick();
        @(negedge CLK);
        if (m_if.Dvalid === 1'b1 && m_if.Dready === 1'b1) begin
            if (sbq.size() == 0) chk("sb_unexpected_word", sbq.size(), 1);
            else                 chk("sb_dout", m_if.Dout, sbq.pop_front());
        end
        @(posedge CLK);
        #1;
        cyc++;
        if (rand_ready) m_if.Dready = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset(input int n);
        RESET = 1'b1;
        repeat (n) tick();
        RESET = 1'b0;
        sbq.delete();
    endtask

    task automatic send_token(input logic [63:0] d, input int budget, output bit acked);
        m_if.Din = d;
        m_if.Si  = 1'b1;
        acked    = 1'b0;
        for (int i = 0; i < budget && !acked; i++) begin
            tick();
            if (m_if.So === 1'b1) acked = 1'b1;
        end
        if (acked) sbq.push_back(d);
    endtask

    task automatic release_si(input int budget, output bit dropped);
        m_if.Si = 1'b0;
        dropped = 1'b0;
        for (int i = 0; i < budget && !dropped; i++) begin
            tick();
            if (m_if.So === 1'b0) dropped = 1'b1;
        end
    endtask

    task automatic token(input logic [63:0] d);
        bit a;
        bit r;
        send_token(d, 40, a);
        chk("token_ack", a, 1'b1);
        release_si(10, r);
        chk("token_so_drop", r, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bp_vec_t     bp[5];
        bit          a;
        bit          r;
        logic [63:0] d;

        for (int i = 0; i < 5; i++) begin
            bp[i].din       = 64'(i);
            bp[i].exp_ack   = (i < 4);
            bp[i].exp_level = (i < 4) ? i + 1 : 4;
        end

        // Reset held with the request already high
        RESET       = 1'b1;
        m_if.Si     = 1'b1;
        m_if.Din    = '0;
        m_if.Dready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_so", m_if.So, 0);
            chk("rst_dvalid", m_if.Dvalid, 0);
            chk("rst_level", m_if.Level, 0);
            chk("rst_rxcount", m_if.RxCount, 0);
            chk("rst_protoerr", m_if.ProtoErr, 0);
        end
        RESET   = 1'b0;
        m_if.Si = 1'b0;
        tick();
        tick();

        // Single token with exact latency
        m_if.Din = 64'hDEADBEEF_00000001;
        m_if.Si  = 1'b1;
        tick();
        chk("t2_so_at_n", m_if.So, 0);
        tick();
        chk("t2_so_at_n1", m_if.So, 0);
        chk("t2_dvalid_at_n1", m_if.Dvalid, 0);
        tick();
        chk("t2_so_at_n2", m_if.So, 1);
        chk("t2_dvalid_at_n2", m_if.Dvalid, 1);
        chk("t2_dout", m_if.Dout, 64'hDEADBEEF_00000001);
        chk("t2_level", m_if.Level, 1);
        sbq.push_back(64'hDEADBEEF_00000001);
        repeat (3) tick();
        m_if.Si = 1'b0;
        tick();
        chk("t2_so_at_m", m_if.So, 1);
        tick();
        chk("t2_so_at_m1", m_if.So, 1);
        tick();
        chk("t2_so_at_m2", m_if.So, 0);
        chk("t2_rxcount", m_if.RxCount, 1);
        m_if.Dready = 1'b1;
        tick();
        m_if.Dready = 1'b0;
        chk("t2_dvalid_after_pop", m_if.Dvalid, 0);
        chk("t2_sb_empty", sbq.size(), 0);

        // Backpressure: four fit, the fifth stalls
        for (int i = 0; i < 5; i++) begin
            send_token(bp[i].din, 12, a);
            chk("bp_ack", a, bp[i].exp_ack);
            chk("bp_level", m_if.Level, bp[i].exp_level);
            if (a) begin
                release_si(10, r);
                chk("bp_so_drop", r, 1'b1);
            end
        end
        chk("bp_stall_so", m_if.So, 0);
        m_if.Dready = 1'b1;
        tick();
        m_if.Dready = 1'b0;
        chk("bp_pop_push_so", m_if.So, 1);
        chk("bp_pop_push_level", m_if.Level, 4);
        chk("bp_head_after_pop", m_if.Dout, 64'h1);
        sbq.push_back(64'h4);
        release_si(10, r);
        chk("bp_final_drop", r, 1'b1);

        // Request withdrawn while the FIFO is full
        m_if.Din = 64'hBAD;
        m_if.Si  = 1'b1;
        repeat (6) tick();
        chk("pe_stall_so", m_if.So, 0);
        chk("pe_before", m_if.ProtoErr, 0);
        m_if.Si = 1'b0;
        repeat (4) tick();
        chk("pe_set", m_if.ProtoErr, 1);
        chk("pe_level", m_if.Level, 4);
        chk("pe_so", m_if.So, 0);
        m_if.Dready = 1'b1;
        repeat (6) tick();
        m_if.Dready = 1'b0;
        chk("pe_drained", sbq.size(), 0);
        chk("pe_level_drained", m_if.Level, 0);
        chk("pe_sticky", m_if.ProtoErr, 1);

        // Stream with random consumer readiness
        do_reset(2);
        chk("st_protoerr_cleared", m_if.ProtoErr, 0);
        rand_ready = 1'b1;
        for (int i = 0; i < 16; i++) token(64'(i));
        rand_ready  = 1'b0;
        m_if.Dready = 1'b1;
        repeat (10) tick();
        chk("st_sb_empty", sbq.size(), 0);
        chk("st_dvalid", m_if.Dvalid, 0);
        chk("st_rxcount", m_if.RxCount, 16);
        chk("st_c4_rxcount_wrap", c4_if.RxCount, 0);
        token(64'h10);
        chk("st_rxcount17", m_if.RxCount, 17);
        chk("st_c4_rxcount17", c4_if.RxCount, 1);
        repeat (4) tick();
        chk("st_sb_empty17", sbq.size(), 0);
        m_if.Dready = 1'b0;

        // Reset in the middle of a handshake
        do_reset(1);
        d = 64'hCAFE_F00D_0000_0006;
        send_token(d, 10, a);
        chk("rm_ack", a, 1'b1);
        chk("rm_s0_so_before", s0_if.So, 1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        sbq.delete();
        chk("rm_so", m_if.So, 0);
        chk("rm_level", m_if.Level, 0);
        chk("rm_rxcount", m_if.RxCount, 0);
        chk("rm_s0_so", s0_if.So, 0);
        chk("rm_s0_level", s0_if.Level, 0);
        tick();
        chk("rm_s0_so_r1", s0_if.So, 1);
        chk("rm_s0_rxcount", s0_if.RxCount, 1);
        chk("rm_so_r1", m_if.So, 0);
        tick();
        chk("rm_so_r2", m_if.So, 0);
        tick();
        chk("rm_so_r3", m_if.So, 1);
        chk("rm_rxcount_r3", m_if.RxCount, 1);
        chk("rm_level_r3", m_if.Level, 1);
        sbq.push_back(d);
        release_si(10, r);
        chk("rm_drop", r, 1'b1);
        m_if.Dready = 1'b1;
        repeat (3) tick();
        m_if.Dready = 1'b0;
        chk("rm_sb_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
